// File: rtl/z80_wr_fifo.sv
// Synchronous first-word-fall-through FIFO for captured Z80 writes.
// The head is visible whenever valid is high. A push into a full FIFO is
// accepted only when a pop in the same cycle frees a slot.
module z80_wr_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign valid   = (cnt != '0);
  assign full    = (cnt == CW'(DEPTH));
  assign do_pop  = pop & valid;
  assign do_push = push & (~full | do_pop);
  assign head    = valid ? mem[rd_ptr] : '0;
  assign count   = cnt;

  // Storage array; pointer state decides which entries are live, so no reset is needed here
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally; occupancy is tracked directly so full and empty never alias
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (do_push && !do_pop) begin
        cnt <= cnt + CW'(1);
      end else if (do_pop && !do_push) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: rtl/z80_wr_capture_fifo.sv
// Captures Z80 write strobes sampled in the clk domain, filters them by an
// address window and queues (address, data) pairs behind a valid/ready port.
// A sticky overflow flag records qualified writes that found the queue full.
module z80_wr_capture_fifo #(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 8,
  parameter int                    SYNC_LEN   = 2,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] ADDR_MATCH = '0,
  parameter logic [ADDR_WIDTH-1:0] ADDR_MASK  = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_req_async,
  input  logic [ADDR_WIDTH-1:0]      ain,
  input  logic [DATA_WIDTH-1:0]      din,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDR_WIDTH-1:0]      aout,
  output logic [DATA_WIDTH-1:0]      dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  input  logic                       ovf_clr
);

  localparam int W = ADDR_WIDTH + DATA_WIDTH;

  logic [SYNC_LEN-1:0] sync_chain;
  logic [SYNC_LEN-1:0] sync_ok;
  logic                s;
  logic                s_valid;
  logic                s_d;
  logic                armed;
  logic                rise;
  logic                pending_valid;
  logic [W-1:0]        pending_data;
  logic                fifo_full;
  logic                drop;
  logic [W-1:0]        head;

  function automatic logic addr_hit(input logic [ADDR_WIDTH-1:0] a);
    return (a & ADDR_MASK) == (ADDR_MATCH & ADDR_MASK);
  endfunction

  assign s       = sync_chain[SYNC_LEN-1];
  assign s_valid = sync_ok[SYNC_LEN-1];
  assign rise    = s & ~s_d & armed;
  assign drop    = pending_valid & fifo_full & ~out_ready;
  assign aout    = head[W-1:DATA_WIDTH];
  assign dout    = head[DATA_WIDTH-1:0];

  // Strobe synchroniser plus a parallel chain that marks when s reflects a real sample
  // rather than the reset value; armed waits for a genuine low so a strobe that spans
  // reset is never taken for a new write.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_chain <= '0;
      sync_ok    <= '0;
      s_d        <= 1'b0;
      armed      <= 1'b0;
    end else begin
      sync_chain <= {sync_chain[SYNC_LEN-2:0], wr_req_async};
      sync_ok    <= {sync_ok[SYNC_LEN-2:0], 1'b1};
      s_d        <= s;
      armed      <= armed | (s_valid & ~s);
    end
  end

  // Bus capture on the strobe edge; ain/din have been stable for the whole synchroniser delay
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_valid <= 1'b0;
      pending_data  <= '0;
    end else begin
      pending_valid <= rise & addr_hit(ain);
      if (rise) begin
        pending_data <= {ain, din};
      end
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps the flag set
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  z80_wr_fifo #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (pending_valid),
    .push_data (pending_data),
    .full      (fifo_full),
    .pop       (out_ready),
    .head      (head),
    .valid     (out_valid),
    .count     (count)
  );

endmodule

// File: tb/tb_z80_wr_capture_fifo.sv
// Self-checking bench for z80_wr_capture_fifo: directed scenarios followed by
// random strobes, all checked each cycle against a queue-based reference model.
module tb_z80_wr_capture_fifo;

  localparam int         AW       = 8;
  localparam int         DW       = 8;
  localparam int         SYNC_LEN = 2;
  localparam int         DEPTH    = 4;
  localparam logic [7:0] MATCH    = 8'h40;
  localparam logic [7:0] MASK     = 8'hF0;
  localparam int         CW       = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_req_async;
  logic [AW-1:0] ain;
  logic [DW-1:0] din;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] aout;
  logic [DW-1:0] dout;
  logic [CW-1:0] count;
  logic          overflow;
  logic          ovf_clr;

  typedef struct {
    int unsigned cyc;
    logic [15:0] val;
  } sched_t;

  logic [15:0] model_q [$];
  sched_t      sched [$];
  logic        model_ovf;
  int unsigned cyc;
  int          checks;
  int          failures;
  int          ready_mode;
  logic        clr_on_push;

  z80_wr_capture_fifo #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .SYNC_LEN   (SYNC_LEN),
    .DEPTH      (DEPTH),
    .ADDR_MATCH (MATCH),
    .ADDR_MASK  (MASK)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_req_async (wr_req_async),
    .ain          (ain),
    .din          (din),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .aout         (aout),
    .dout         (dout),
    .count        (count),
    .overflow     (overflow),
    .ovf_clr      (ovf_clr)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // One clock edge: advance the model with the inputs held across the edge, then compare
  task automatic tick();
    logic       pop;
    logic       drop;
    sched_t     e;
    @(posedge clk);
    cyc++;
    if (reset) begin
      model_q.delete();
      sched.delete();
      model_ovf = 1'b0;
    end else begin
      pop  = (model_q.size() > 0) && out_ready;
      drop = 1'b0;
      if (pop) void'(model_q.pop_front());
      if (sched.size() > 0 && sched[0].cyc == cyc) begin
        e = sched.pop_front();
        if (model_q.size() < DEPTH) model_q.push_back(e.val);
        else drop = 1'b1;
      end
      if (drop) model_ovf = 1'b1;
      else if (ovf_clr) model_ovf = 1'b0;
    end
    #1;
    checkOutput("out_valid", 32'(out_valid), 32'(model_q.size() > 0));
    checkOutput("count", 32'(count), 32'(model_q.size()));
    checkOutput("overflow", 32'(overflow), 32'(model_ovf));
    if (model_q.size() > 0) begin
      checkOutput("aout", 32'(aout), 32'(model_q[0][15:8]));
      checkOutput("dout", 32'(dout), 32'(model_q[0][7:0]));
    end
  endtask

  // Drives out_ready/ovf_clr according to the current mode, then clocks once
  task automatic cycle();
    logic push_next;
    push_next = (sched.size() > 0) && (sched[0].cyc == cyc + 1);
    if (ready_mode == 1) begin
      out_ready = 1'($urandom_range(0, 1));
      ovf_clr   = ($urandom_range(0, 7) == 0);
    end else if (ready_mode == 2) begin
      out_ready = push_next;
    end
    if (clr_on_push) ovf_clr = push_next;
    tick();
  endtask

  // One CPU write strobe with the given address, data and high/low widths
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] d, input int hi, input int lo);
    sched_t e;
    ain          = a;
    din          = d;
    wr_req_async = 1'b1;
    if ((a & MASK) == (MATCH & MASK)) begin
      e.cyc = cyc + SYNC_LEN + 2;
      e.val = {a, d};
      sched.push_back(e);
    end
    repeat (hi) cycle();
    wr_req_async = 1'b0;
    repeat (lo) cycle();
  endtask

  task automatic doReset(input int n);
    reset = 1'b1;
    repeat (n) cycle();
    reset = 1'b0;
    repeat (6) cycle();
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    cyc          = 0;
    model_ovf    = 1'b0;
    ready_mode   = 0;
    clr_on_push  = 1'b0;
    reset        = 1'b1;
    wr_req_async = 1'b0;
    ain          = '0;
    din          = '0;
    out_ready    = 1'b0;
    ovf_clr      = 1'b0;

    // Reset state
    repeat (3) tick();
    checkOutput("rst_aout", 32'(aout), 32'h0);
    checkOutput("rst_dout", 32'(dout), 32'h0);
    reset = 1'b0;
    repeat (6) cycle();

    // Single write with consumer ready
    $display("[TB] single write");
    out_ready = 1'b1;
    applyStimulus(8'h42, 8'hA5, 8, 6);

    // Backpressure, fill and overflow, then drain in order and clear
    $display("[TB] backpressure");
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) applyStimulus(8'h40, 8'(i), 4, 4);
    checkOutput("fill_count", 32'(count), 32'd4);
    checkOutput("fill_ovf", 32'(overflow), 32'd1);
    out_ready = 1'b1;
    repeat (6) cycle();
    ovf_clr = 1'b1;
    cycle();
    ovf_clr = 1'b0;
    cycle();

    // Full FIFO with a pop on the exact cycle a push lands
    $display("[TB] full with simultaneous pop");
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(8'h45, 8'h10 + 8'(i), 4, 4);
    ready_mode = 2;
    applyStimulus(8'h46, 8'hEE, 4, 4);
    ready_mode = 0;
    checkOutput("fullpop_count", 32'(count), 32'd4);
    checkOutput("fullpop_ovf", 32'(overflow), 32'd0);
    out_ready = 1'b1;
    repeat (6) cycle();

    // Address filter
    $display("[TB] address filter");
    out_ready = 1'b0;
    applyStimulus(8'h41, 8'h11, 4, 4);
    applyStimulus(8'h7F, 8'h22, 4, 4);
    applyStimulus(8'h4E, 8'h33, 4, 4);
    checkOutput("filter_count", 32'(count), 32'd2);

    // Reset while a strobe is high and two entries are queued
    $display("[TB] reset mid-strobe");
    begin
      sched_t e;
      ain          = 8'h43;
      din          = 8'h77;
      wr_req_async = 1'b1;
      e.cyc        = cyc + SYNC_LEN + 2;
      e.val        = {8'h43, 8'h77};
      sched.push_back(e);
      repeat (6) cycle();
      reset = 1'b1;
      repeat (2) cycle();
      reset = 1'b0;
      checkOutput("midrst_count", 32'(count), 32'd0);
      repeat (6) cycle();
      wr_req_async = 1'b0;
      repeat (6) cycle();
      checkOutput("midrst_valid", 32'(out_valid), 32'd0);
    end
    out_ready = 1'b1;
    applyStimulus(8'h44, 8'h88, 4, 6);

    // Clear colliding with a drop keeps overflow set
    $display("[TB] ovf_clr collision");
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(8'h4A, 8'h50 + 8'(i), 4, 4);
    clr_on_push = 1'b1;
    applyStimulus(8'h4B, 8'h99, 4, 4);
    clr_on_push = 1'b0;
    ovf_clr     = 1'b0;
    checkOutput("collide_ovf", 32'(overflow), 32'd1);
    out_ready = 1'b1;
    ovf_clr   = 1'b1;
    cycle();
    ovf_clr = 1'b0;
    repeat (6) cycle();

    // Randomised strobes with random backpressure and clears
    $display("[TB] random traffic");
    ready_mode = 1;
    for (int n = 0; n < 60; n++) begin
      logic [7:0] a;
      a = ($urandom_range(0, 3) != 0) ? (8'h40 | 8'($urandom_range(0, 15))) : 8'($urandom);
      applyStimulus(a, 8'($urandom), $urandom_range(SYNC_LEN + 1, SYNC_LEN + 4),
                    $urandom_range(SYNC_LEN + 1, SYNC_LEN + 4));
    end
    ready_mode = 0;
    out_ready  = 1'b1;
    ovf_clr    = 1'b0;
    repeat (8) cycle();
    checkOutput("final_count", 32'(count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/z80_wr_capture_fifo.md
Name: z80_wr_capture_fifo

Overview:
Captures Z80 write cycles into a single clock domain by sampling the CPU write strobe directly in the target clock (`clk`).
- Accepts an asynchronous write-strobe level plus the address and data buses.
- Synchronises the strobe and detects its rising edge.
- Filters by address window and queues (address, data) pairs in a DEPTH-entry FIFO.
- Presents the queue on a valid/ready interface.

It replaces the single-tick crossing for peripherals that must not lose back-to-back CPU writes.

Parameters:
- ADDR_WIDTH, 8, address bus width.
- DATA_WIDTH, 8, data bus width.
- SYNC_LEN, 2, strobe synchroniser flop count (>=2).
- DEPTH, 4, FIFO entries; power of two, >=2.
- ADDR_MATCH, 0, address compare value.
- ADDR_MASK, 0, compare mask; bit=1 means compared. All-zero accepts every address.

Ports:
- clk  in  1  target-domain clock; only clock in the block.
- reset  in  1  synchronous, active-high reset.
- wr_req_async  in  1  CPU write strobe (decoded iorq&wr, active-high level), asynchronous to clk.
- ain  in  ADDR_WIDTH  CPU address; stable for the whole time wr_req_async is high.
- din  in  DATA_WIDTH  CPU data; stable for the whole time wr_req_async is high.
- out_valid  out  1  FIFO head holds a captured write.
- out_ready  in  1  consumer accepts the head this cycle.
- aout  out  ADDR_WIDTH  head address.
- dout  out  DATA_WIDTH  head data.
- count  out  $clog2(DEPTH+1)  occupied entries.
- overflow  out  1  sticky: a qualified write was dropped because the FIFO was full.
- ovf_clr  in  1  clears overflow.

Behaviour:
- Reset (sync, active-high, clk domain) forces:
  - synchroniser flops, edge register and armed flag = 0;
  - out_valid = 0, count = 0, overflow = 0;
  - aout and dout = 0; FIFO pointers = 0.
- Synchroniser: SYNC_LEN-flop chain on wr_req_async gives `s`; edge register holds `s_d`.
- Rising edge: `rise = s & ~s_d & armed`.
  - `armed` sets the first cycle `s == 0` after reset.
  - A strobe already high when reset deasserts is therefore ignored.
- Capture: on `rise`, ain/din are sampled directly; they have been stable >= SYNC_LEN cycles, so no synchroniser is needed on the buses.
  - Qualified when `(ain & ADDR_MASK) == (ADDR_MATCH & ADDR_MASK)`.
  - Unqualified writes produce no FIFO activity and no overflow.
- Push: a qualified capture is registered into pending and pushed on the next edge.
  - With wr_req_async set up just after edge E0, out_valid rises at edge E(SYNC_LEN+2) for an empty FIFO, i.e. E4 with default parameters.
  - Asynchronous sampling may add one cycle.
- Throughput: one push per strobe. Minimum strobe high and low widths are SYNC_LEN+1 clk cycles each; shorter pulses may be missed, and that is not an error.
- FIFO is first-word fall-through:
  - aout/dout show the head whenever out_valid = 1;
  - they hold stable while out_valid & ~out_ready;
  - they are don't-care when out_valid = 0.
- Pop: on out_valid & out_ready. Pop when empty is impossible because out_valid = 0.
- Simultaneous push and pop:
  - count is unchanged;
  - this is also true when full: the pop frees the slot and the push is accepted, with no overflow.
- Full without pop: a qualified push is dropped and overflow is set on the same edge. FIFO contents are unchanged.
- overflow: ovf_clr clears it on the next edge. If ovf_clr and a new drop occur in the same cycle, the set wins.
- Pointers are log2(DEPTH) bits and wrap naturally. count = wr_count - rd_count, tracked directly; count == DEPTH means full.
- Reset mid-write: pending capture and all entries are discarded. The in-flight strobe is not re-detected (armed = 0).

Decomposition:
- No shared package is needed; widths come from parameters.
- The address-qualify function is a local function.
- Sub-module `z80_wr_fifo`: synchronous FWFT FIFO.
  - Parameters: WIDTH = ADDR_WIDTH + DATA_WIDTH, DEPTH.
  - Ports: clk, reset, push, push_data, full, pop, head, valid, count.
- The synchroniser, edge detect, armed flag, qualify logic and overflow stay in the top module.

Test Plan:
- Single write: wr_req_async high 8 cycles with ain = 8'h42, din = 8'hA5, out_ready = 1 → out_valid high one cycle at E4 with aout = 42, dout = A5; count returns to 0; overflow = 0.
- Backpressure and fill: out_ready = 0; five writes with data 01..05, DEPTH = 4 → count = 4 and overflow = 1 after the fifth. Then out_ready = 1 → heads pop in order 01, 02, 03, 04, with data held stable while stalled. ovf_clr → overflow = 0.
- Full with simultaneous pop: FIFO full, out_ready = 1 in the cycle a pending push lands → count stays 4, overflow = 0, new entry is last out.
- Address filter: ADDR_MATCH = 8'h40, ADDR_MASK = 8'hF0; writes to 0x41, 0x7F, 0x4E → only 0x41 and 0x4E are queued; count = 2.
- Reset mid-strobe: assert reset for 2 cycles while wr_req_async is high and 2 entries are queued → count = 0, out_valid = 0, no capture from the ongoing strobe. The next full strobe is captured normally.
- ovf_clr collision: ovf_clr asserted in the same cycle as a full-FIFO drop → overflow remains 1.
